cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Instruction sequencer for the 4-bit processor, directly upstream of the accumulator write-back mux.
- Fetches an 8-bit instruction from program ROM and decodes it.
- Drives the mux select, the 4-bit immediate "load" operand, the ALU opcode and the accumulator write enable.
- Owns the program counter, jumps, conditional branches and halt.

Parameters:
- PC_W, 4, program counter width (ROM depth = 2^PC_W).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  1 = allow the next fetch; 0 = stall in FETCH.
- instr  input  8  ROM data at address pc; [7:4] opcode, [3:0] immediate.
- zero_flag  input  1  registered ALU zero flag from the last write-back.
- carry_flag  input  1  registered ALU carry flag from the last write-back.
- pc  output  PC_W  ROM address.
- select  output  1  write-back mux select; 1 = load (immediate), 0 = alu.
- load  output  4  immediate operand to the mux load input and the ALU B input.
- alu_op  output  3  ALU function code.
- acc_we  output  1  accumulator write enable, one-cycle pulse.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, ir=0, select=0, load=0, alu_op=0, acc_we=0, halted=0. Mid-instruction reset aborts immediately; no acc_we is produced.
- States: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is terminal until reset.
- FETCH:
  - run=1: ir<=instr, pc<=pc+1 (wraps 2^PC_W-1 -> 0), go to DECODE.
  - run=0: hold state; pc and ir unchanged.
- DECODE:
  - load<=ir[3:0].
  - alu_op and select are set from the opcode.
  - Both are registered and held stable through EXECUTE and WRITEBACK.
- Opcode map:
  - 0 NOP.
  - 1 LDI: select=1.
  - 2 ADD: alu_op=000.
  - 3 SUB: alu_op=001.
  - 4 AND: alu_op=010.
  - 5 OR: alu_op=011.
  - 6 XOR: alu_op=100.
  - 7 NOT: alu_op=101.
  - 8 JMP imm.
  - 9 JZ imm.
  - A JC imm.
  - F HLT.
  - B–E: treated as NOP.
  - For every non-ALU opcode: select=0, alu_op=000.
- EXECUTE:
  - JMP: pc<=ir[3:0] (zero-extended to PC_W).
  - JZ: pc<=ir[3:0] if zero_flag=1.
  - JC: pc<=ir[3:0] if carry_flag=1.
  - Flags are sampled in this cycle and are those of the previous write-back.
  - HLT: go to HALT, halted<=1.
  - All others: no PC change.
- WRITEBACK:
  - acc_we=1 for exactly this cycle for LDI and ALU ops (opcodes 1–7).
  - acc_we=0 for NOP, jumps and reserved opcodes.
  - Then go to FETCH.
- Latency: 4 cycles per instruction when run is held high. The first FETCH occurs the cycle after reset deassertion.
- acc_we is registered, glitch-free and never high outside WRITEBACK.
- HALT: pc, ir and outputs are frozen; acc_we=0. The run input is ignored.
- PC wrap: sequential execution past address 2^PC_W-1 continues at 0 with no error.
- Jump to the current address (self-loop) is legal and repeats indefinitely.

Test Plan:
- Reset then run=1, ROM[0]=0x15 (LDI 5) -> cycle 4: select=1, load=5, acc_we=1 for one cycle; pc=1.
- ROM[1]=0x23 (ADD 3) -> DECODE..WRITEBACK: select=0, alu_op=000, load=3; acc_we in WRITEBACK only.
- JZ: ROM[2]=0x9A with zero_flag=0 -> next fetch at pc=3. Repeat with zero_flag=1 -> next fetch at pc=0xA. Same pair of checks for JC using carry_flag.
- run=0 held 5 cycles in FETCH -> pc, state and outputs unchanged, acc_we=0. Raising run resumes within 1 cycle.
- ROM[0xF]=0x00 executed sequentially -> pc wraps to 0. ROM[x]=0xF0 -> halted=1 and stays high for 20 cycles; acc_we=0 throughout.
- Assert rst_n=0 during EXECUTE of an ADD -> outputs clear asynchronously, no acc_we pulse, fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Instruction sequencer for the 4-bit processor.
// Fetches and decodes ROM words, drives the write-back mux, ALU and PC.
module cpu_control_fsm #(
  parameter int PC_W     = 4,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [7:0]      instr,
  input  logic            zero_flag,
  input  logic            carry_flag,
  output logic [PC_W-1:0] pc,
  output logic            select,
  output logic [3:0]      load,
  output logic [2:0]      alu_op,
  output logic            acc_we,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      ir, ir_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            select_nxt;
  logic [3:0]      load_nxt;
  logic [2:0]      alu_op_nxt;
  logic            acc_we_nxt;
  logic            halted_nxt;

  logic [3:0]      op;
  logic [PC_W-1:0] target;
  logic [2:0]      dec_alu;
  logic            is_ldi;
  logic            is_alu;
  logic            is_jmp;
  logic            is_jz;
  logic            is_jc;
  logic            is_hlt;

  assign op     = ir[7:4];
  assign target = PC_W'(ir[3:0]);

  always_comb begin
    dec_alu = 3'b000;
    is_ldi  = 1'b0;
    is_alu  = 1'b0;
    is_jmp  = 1'b0;
    is_jz   = 1'b0;
    is_jc   = 1'b0;
    is_hlt  = 1'b0;
    unique case (op)
      4'h1: is_ldi = 1'b1;
      4'h2: begin is_alu = 1'b1; dec_alu = 3'b000; end
      4'h3: begin is_alu = 1'b1; dec_alu = 3'b001; end
      4'h4: begin is_alu = 1'b1; dec_alu = 3'b010; end
      4'h5: begin is_alu = 1'b1; dec_alu = 3'b011; end
      4'h6: begin is_alu = 1'b1; dec_alu = 3'b100; end
      4'h7: begin is_alu = 1'b1; dec_alu = 3'b101; end
      4'h8: is_jmp = 1'b1;
      4'h9: is_jz  = 1'b1;
      4'hA: is_jc  = 1'b1;
      4'hF: is_hlt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= PC_W'(RESET_PC);
      ir     <= 8'h00;
      select <= 1'b0;
      load   <= 4'h0;
      alu_op <= 3'b000;
      acc_we <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      ir     <= ir_nxt;
      select <= select_nxt;
      load   <= load_nxt;
      alu_op <= alu_op_nxt;
      acc_we <= acc_we_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    select_nxt = select;
    load_nxt   = load;
    alu_op_nxt = alu_op;
    acc_we_nxt = 1'b0;
    halted_nxt = halted;
    unique case (state)
      S_FETCH: begin
        if (run) begin
          ir_nxt    = instr;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        load_nxt   = ir[3:0];
        select_nxt = is_ldi;
        alu_op_nxt = dec_alu;
        state_nxt  = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_nxt  = S_WRITEBACK;
        // registered here so the pulse lines up with WRITEBACK exactly
        acc_we_nxt = is_ldi | is_alu;
        unique case (1'b1)
          is_jmp: pc_nxt = target;
          is_jz:  if (zero_flag)  pc_nxt = target;
          is_jc:  if (carry_flag) pc_nxt = target;
          is_hlt: begin
            state_nxt  = S_HALT;
            halted_nxt = 1'b1;
          end
          default: ;
        endcase
      end
      S_WRITEBACK: state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm.
// A small ROM array is driven combinationally from pc.
module tb_cpu_control_fsm;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] instr;
  logic       zero_flag;
  logic       carry_flag;
  logic [3:0] pc;
  logic       select;
  logic [3:0] load;
  logic [2:0] alu_op;
  logic       acc_we;
  logic       halted;

  logic [7:0] rom [16];
  int         nvec;
  int         nbad;

  cpu_control_fsm #(.PC_W(4), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .instr      (instr),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .pc         (pc),
    .select     (select),
    .load       (load),
    .alu_op     (alu_op),
    .acc_we     (acc_we),
    .halted     (halted)
  );

  assign instr = rom[pc];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT in FETCH and run=1.
  task automatic run_instr(input string tag,
                           input logic       e_sel,
                           input logic [3:0] e_load,
                           input logic [2:0] e_alu,
                           input logic       e_we,
                           input logic [3:0] e_pc);
    @(negedge clk);
    chk({tag, "_dec_we"}, 8'(acc_we), 8'h0);
    @(negedge clk);
    chk({tag, "_ex_sel"}, 8'(select), 8'(e_sel));
    chk({tag, "_ex_load"}, 8'(load), 8'(e_load));
    chk({tag, "_ex_alu"}, 8'(alu_op), 8'(e_alu));
    chk({tag, "_ex_we"}, 8'(acc_we), 8'h0);
    @(negedge clk);
    chk({tag, "_wb_we"}, 8'(acc_we), 8'(e_we));
    chk({tag, "_wb_sel"}, 8'(select), 8'(e_sel));
    @(negedge clk);
    chk({tag, "_fe_we"}, 8'(acc_we), 8'h0);
    chk({tag, "_fe_pc"}, 8'(pc), 8'(e_pc));
  endtask

  initial begin
    nvec       = 0;
    nbad       = 0;
    rst_n      = 1'b0;
    run        = 1'b0;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h15;
    rom[1]  = 8'h23;
    rom[2]  = 8'h9A;
    rom[3]  = 8'hA8;
    rom[4]  = 8'h37;
    rom[5]  = 8'h6F;
    rom[6]  = 8'hB1;
    rom[7]  = 8'h82;
    rom[10] = 8'hAC;
    rom[12] = 8'h8E;

    @(negedge clk);
    chk("rst_pc", 8'(pc), 8'h0);
    chk("rst_sel", 8'(select), 8'h0);
    chk("rst_load", 8'(load), 8'h0);
    chk("rst_alu", 8'(alu_op), 8'h0);
    chk("rst_we", 8'(acc_we), 8'h0);
    chk("rst_halt", 8'(halted), 8'h0);

    rst_n = 1'b1;
    run   = 1'b1;
    run_instr("ldi5", 1'b1, 4'h5, 3'd0, 1'b1, 4'h1);
    run_instr("add3", 1'b0, 4'h3, 3'd0, 1'b1, 4'h2);
    run_instr("jz_n", 1'b0, 4'hA, 3'd0, 1'b0, 4'h3);
    run_instr("jc_n", 1'b0, 4'h8, 3'd0, 1'b0, 4'h4);
    run_instr("sub7", 1'b0, 4'h7, 3'd1, 1'b1, 4'h5);
    run_instr("xorf", 1'b0, 4'hF, 3'd4, 1'b1, 4'h6);
    run_instr("rsvd", 1'b0, 4'h1, 3'd0, 1'b0, 4'h7);
    run_instr("jmp2", 1'b0, 4'h2, 3'd0, 1'b0, 4'h2);
    zero_flag = 1'b1;
    run_instr("jz_y", 1'b0, 4'hA, 3'd0, 1'b0, 4'hA);
    carry_flag = 1'b1;
    run_instr("jc_y", 1'b0, 4'hC, 3'd0, 1'b0, 4'hC);
    run_instr("jmpe", 1'b0, 4'hE, 3'd0, 1'b0, 4'hE);
    run_instr("nope", 1'b0, 4'h0, 3'd0, 1'b0, 4'hF);
    run_instr("wrap", 1'b0, 4'h0, 3'd0, 1'b0, 4'h0);

    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", 8'(pc), 8'h0);
      chk("stall_we", 8'(acc_we), 8'h0);
      chk("stall_sel", 8'(select), 8'h0);
      chk("stall_load", 8'(load), 8'h0);
    end
    run = 1'b1;
    @(negedge clk);
    chk("resume_pc", 8'(pc), 8'h1);
    @(negedge clk);
    chk("resume_sel", 8'(select), 8'h1);
    chk("resume_load", 8'(load), 8'h5);
    @(negedge clk);
    chk("resume_we", 8'(acc_we), 8'h1);
    @(negedge clk);
    chk("resume_pc2", 8'(pc), 8'h1);

    @(negedge clk);
    chk("abort_pc", 8'(pc), 8'h2);
    @(negedge clk);
    chk("abort_ex_load", 8'(load), 8'h3);
    #2;
    rst_n  = 1'b0;
    rom[0] = 8'hF0;
    #1;
    chk("abort_pc0", 8'(pc), 8'h0);
    chk("abort_load", 8'(load), 8'h0);
    chk("abort_sel", 8'(select), 8'h0);
    chk("abort_we", 8'(acc_we), 8'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_hold_we", 8'(acc_we), 8'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_pc", 8'(pc), 8'h1);
    @(negedge clk);
    chk("hlt_ex_halt", 8'(halted), 8'h0);
    @(negedge clk);
    chk("hlt_halt", 8'(halted), 8'h1);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) run = 1'b0;
      @(negedge clk);
      chk("hlt_hold", 8'(halted), 8'h1);
      chk("hlt_we", 8'(acc_we), 8'h0);
      chk("hlt_pc", 8'(pc), 8'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
